// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one main-memory port between the I-cache and the D-cache.
// Optional build macro MEM_ARB_DCACHE_PRIO_EN: on a tie the D-cache always wins.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic [DATA_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_busy
);

  // state   | meaning
  // IDLE    | no grant; memory request lines held low (turnaround cycle)
  // GRANT_I | I-cache owns the memory port until mem_ready or drop
  // GRANT_D | D-cache owns the memory port until mem_ready or drop
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t state;
  logic   last_grant;
  logic   req_i;
  logic   req_d;
  logic   pick_d;

  assign req_i = ic_mem_read;
  assign req_d = dc_mem_read | dc_mem_write;

`ifdef MEM_ARB_DCACHE_PRIO_EN
  assign pick_d = req_d;
`else
  // On a tie, serve whichever master was not granted last.
  assign pick_d = req_d & (~req_i | ~last_grant);
`endif

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_i | req_d) begin
            state      <= pick_d ? GRANT_D : GRANT_I;
            last_grant <= pick_d;
          end
        end
        GRANT_I: if (mem_ready || !req_i) state <= IDLE;
        GRANT_D: if (mem_ready || !req_d) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Forwarding is combinational from the registered grant, so ready and rdata add no latency.
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ic_mem_ready = 1'b0;
    dc_mem_ready = 1'b0;
    arb_busy     = 1'b0;
    case (state)
      GRANT_I: begin
        mem_read     = ic_mem_read;
        mem_addr     = ic_mem_addr;
        ic_mem_ready = mem_ready;
        arb_busy     = 1'b1;
      end
      GRANT_D: begin
        mem_read     = dc_mem_read;
        mem_write    = dc_mem_write;
        mem_addr     = dc_mem_addr;
        mem_wdata    = dc_mem_write ? dc_mem_wdata : '0;
        dc_mem_ready = mem_ready;
        arb_busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign ic_mem_rdata = mem_rdata;
  assign dc_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected memory transactions are queued when requests are
// driven and popped when the arbiter presents them to the memory model.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          ic_mem_read;
  logic [AW-1:0] ic_mem_addr;
  logic [DW-1:0] ic_mem_rdata;
  logic          ic_mem_ready;
  logic          dc_mem_read;
  logic          dc_mem_write;
  logic [AW-1:0] dc_mem_addr;
  logic [DW-1:0] dc_mem_wdata;
  logic [DW-1:0] dc_mem_rdata;
  logic          dc_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          arb_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;
  txn_t exp_q[$];

  mem_arbiter dut (
    .clk(clk), .proc_reset(proc_reset),
    .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
    .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
    .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
    .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
    .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata);
    txn_t t;
    t.is_d = is_d; t.wr = wr; t.addr = addr; t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  // Memory model: wait for a request, check it against the scoreboard, answer after lat cycles.
  task automatic serve(input int lat, input logic [DW-1:0] rdata, output logic served_d);
    txn_t t;
    int   n = 0;
    served_d = 1'b0;
    while (!(mem_read | mem_write) && n < 20) begin
      tick();
      n++;
    end
    if (!(mem_read | mem_write)) begin
      check("req_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_req", 0, 1);
      return;
    end
    t = exp_q.pop_front();
    served_d = t.is_d;
    check("busy", arb_busy, 1);
    check("mem_write", mem_write, t.wr);
    check("mem_read", mem_read, !t.wr);
    check("mem_addr", mem_addr, t.addr);
    check("mem_wdata", mem_wdata, t.wdata);
    repeat (lat) tick();
    check("early_ready", {ic_mem_ready, dc_mem_ready}, 2'b00);
    mem_rdata = rdata;
    mem_ready = 1'b1;
    #1;
    check("ic_ready", ic_mem_ready, !t.is_d);
    check("dc_ready", dc_mem_ready, t.is_d);
    check("ic_rdata", ic_mem_rdata, rdata);
    check("dc_rdata", dc_mem_rdata, rdata);
    tick();
    mem_ready = 1'b0;
    #1;
    check("turnaround", {mem_read, mem_write, arb_busy}, 3'b000);
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    tick();
    tick();
    proc_reset = 1'b0;
  endtask

  logic          sd;
  logic [DW-1:0] wd;

  initial begin
    proc_reset   = 1'b0;
    ic_mem_read  = 1'b0;
    ic_mem_addr  = '0;
    dc_mem_read  = 1'b0;
    dc_mem_write = 1'b0;
    dc_mem_addr  = '0;
    dc_mem_wdata = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    wd           = {8{16'h1234}};

    do_reset();
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_readies", {ic_mem_ready, dc_mem_ready}, 2'b00);
    check("rst_busy", arb_busy, 0);

    // I-only read, ready at cycle 5
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h0000010;
    push(1'b0, 1'b0, 28'h0000010, '0);
    #1;
    check("req_latency_c0", mem_read, 0);
    tick();
    check("req_latency_c1", mem_read, 1);
    serve(4, {32{4'hA}}, sd);
    ic_mem_read = 1'b0;

    // Simultaneous requests right after reset
    do_reset();
    ic_mem_read = 1'b1; ic_mem_addr = 28'h10;
    dc_mem_read = 1'b1; dc_mem_addr = 28'h20;
`ifdef MEM_ARB_DCACHE_PRIO_EN
    push(1'b1, 1'b0, 28'h20, '0);
    push(1'b0, 1'b0, 28'h10, '0);
`else
    push(1'b0, 1'b0, 28'h10, '0);
    push(1'b1, 1'b0, 28'h20, '0);
`endif
    serve(2, {4{32'hC0DE0001}}, sd);
    if (sd) dc_mem_read = 1'b0; else ic_mem_read = 1'b0;
    serve(3, {4{32'hC0DE0002}}, sd);
    ic_mem_read = 1'b0;
    dc_mem_read = 1'b0;

    // D write-back then allocate read; wdata left on the bus must be masked on the read
    dc_mem_write = 1'b1; dc_mem_addr = 28'h0000300; dc_mem_wdata = wd;
    push(1'b1, 1'b1, 28'h0000300, wd);
    serve(2, '0, sd);
    dc_mem_write = 1'b0; dc_mem_read = 1'b1; dc_mem_addr = 28'h0000040;
    push(1'b1, 1'b0, 28'h0000040, '0);
    serve(2, {4{32'hBEEF0040}}, sd);
    dc_mem_read = 1'b0;

    // Fairness: both request continuously for six transactions
    do_reset();
    ic_mem_read = 1'b1; ic_mem_addr = 28'h111;
    dc_mem_read = 1'b1; dc_mem_addr = 28'h222;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_DCACHE_PRIO_EN
      push(1'b1, 1'b0, 28'h222, '0);
`else
      if (i % 2 == 0) push(1'b0, 1'b0, 28'h111, '0);
      else            push(1'b1, 1'b0, 28'h222, '0);
`endif
    end
    for (int i = 0; i < 6; i++) serve(1, DW'(i + 1), sd);
    ic_mem_read = 1'b0;
    dc_mem_read = 1'b0;
    tick();

    // Reset mid-transaction during a D write
    dc_mem_write = 1'b1; dc_mem_addr = 28'h0000500; dc_mem_wdata = wd;
    tick();
    check("mid_grant_write", mem_write, 1);
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    dc_mem_write = 1'b0;
    #1;
    check("mid_rst_write", mem_write, 0);
    check("mid_rst_busy", arb_busy, 0);
    mem_ready = 1'b1;
    #1;
    check("mid_rst_ready", {ic_mem_ready, dc_mem_ready}, 2'b00);
    tick();
    mem_ready = 1'b0;

    // Dropped I request: no ready, grant history (I last) kept
    ic_mem_read = 1'b1; ic_mem_addr = 28'h0000777;
    tick();
    check("drop_granted", mem_read, 1);
    ic_mem_read = 1'b0;
    #1;
    check("drop_fwd", mem_read, 0);
    tick();
    check("drop_idle", arb_busy, 0);
    mem_ready = 1'b1;
    #1;
    check("drop_no_ready", ic_mem_ready, 0);
    mem_ready = 1'b0;
    ic_mem_read = 1'b1; ic_mem_addr = 28'h0000888;
    dc_mem_read = 1'b1; dc_mem_addr = 28'h0000999;
    push(1'b1, 1'b0, 28'h0000999, '0);
    push(1'b0, 1'b0, 28'h0000888, '0);
    serve(2, {4{32'h0D0D0D0D}}, sd);
    dc_mem_read = 1'b0;
    serve(2, {4{32'h1C1C1C1C}}, sd);
    ic_mem_read = 1'b0;
    tick();

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and data cache, and upstream of the single shared main memory.
- Multiplexes the two cache-side memory interfaces onto one memory interface using the same protocol. The protocol is level request, 28-bit block address, 128-bit block data, and a one-cycle ready pulse.
- Arbitration is round-robin. Exactly one master is served per transaction. Ready is routed back only to the granted cache.

Parameters:
- ADDR_W, 28, block address width (word address bits [29:2]).
- DATA_W, 128, block data width (4 words).

Ports:
- clk  input  1  clock
- proc_reset  input  1  synchronous active-high reset
- ic_mem_read  input  1  I-cache block read request
- ic_mem_addr  input  ADDR_W  I-cache block address
- ic_mem_rdata  output  DATA_W  read data to I-cache
- ic_mem_ready  output  1  I-cache transaction done
- dc_mem_read  input  1  D-cache block read request
- dc_mem_write  input  1  D-cache block write-back request
- dc_mem_addr  input  ADDR_W  D-cache block address
- dc_mem_wdata  input  DATA_W  D-cache write data
- dc_mem_rdata  output  DATA_W  read data to D-cache
- dc_mem_ready  output  1  D-cache transaction done
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- mem_addr  output  ADDR_W  memory block address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- mem_ready  input  1  memory done pulse (one cycle)
- arb_busy  output  1  high while a transaction is granted

Behaviour:
- Clock and reset: one clock, clk. Reset proc_reset is synchronous and active-high.
- States: IDLE, GRANT_I, GRANT_D (registered). Also registered: a last_grant bit (0=I, 1=D).
- Reset values:
  - state=IDLE, last_grant=1 (so I-cache wins the first tie).
  - All request outputs 0: mem_read, mem_write, mem_addr=0, mem_wdata=0.
  - ic_mem_ready=0, dc_mem_ready=0, arb_busy=0.
- IDLE:
  - All memory outputs are 0.
  - Requesters: I requests if ic_mem_read; D requests if dc_mem_read|dc_mem_write.
  - Only one requester: grant it.
  - Both request: grant the one not equal to last_grant.
  - Grant takes effect at the next edge; last_grant is updated at the same edge.
- GRANT_I:
  - mem_read=ic_mem_read, mem_write=0, mem_addr=ic_mem_addr, mem_wdata=0.
  - ic_mem_ready=mem_ready.
- GRANT_D:
  - mem_read=dc_mem_read, mem_write=dc_mem_write, mem_addr=dc_mem_addr.
  - mem_wdata=dc_mem_wdata when dc_mem_write, else 0.
  - dc_mem_ready=mem_ready.
- Forwarding in grant states is combinational. arb_busy=1 in both grant states.
- Read data: ic_mem_rdata and dc_mem_rdata both equal mem_rdata at all times. Each cache samples only on its own ready.
- Completion: mem_ready in a grant state sends the next state to IDLE. The non-granted ready output is always 0.
- Mandatory turnaround: one IDLE cycle between consecutive transactions. The memory therefore sees request deasserted for at least one cycle.
- Added latency: one cycle from request to memory request; zero cycles on ready and rdata.
- D-cache dirty miss: write-back completes, D then raises read. If I is waiting, I is served first under round-robin; the D read follows.
- Dropped request: if the granted master deasserts all requests before mem_ready, go to IDLE at the next edge, with no ready returned. last_grant is kept.
- Both dc_mem_read and dc_mem_write high is illegal from the D-cache. The arbiter forwards both unchanged and does not check.
- Reset mid-transaction: state goes to IDLE at that edge and outputs go to 0 in the following cycle. A mem_ready arriving in IDLE is ignored; no ready is routed.

Optional Feature:
- Macro MEM_ARB_DCACHE_PRIO_EN.
- Defined: fixed priority. On a tie in IDLE, D-cache always wins; last_grant is still maintained but unused.
- Undefined: round-robin as above.

Test Plan:
- I-only read:
  - Stimulus: ic_mem_read=1, ic_mem_addr=28'h0000010; memory returns rdata=128'hA..A with ready at cycle 5.
  - Response: mem_read=1 and mem_addr=28'h0000010 from cycle 1. ic_mem_ready=1 only at cycle 5, ic_mem_rdata=128'hA..A. dc_mem_ready stays 0. IDLE at cycle 6.
- Simultaneous requests after reset:
  - Stimulus: I read addr 28'h10 and D read addr 28'h20 both held.
  - Response: I is served first; mem_read is 0 for one cycle after I ready; then mem_addr=28'h20 and D is served.
- D write-back then allocate:
  - Stimulus: dc_mem_write=1, addr 28'h0000300, wdata 128'h1234_...; then read addr 28'h0000040.
  - Response: mem_write=1, mem_wdata matches; after ready, 1 idle cycle; then mem_read=1, mem_addr=28'h0000040, mem_wdata=0.
- Round-robin fairness:
  - Stimulus: both caches request continuously for 6 transactions.
  - Response: grant sequence I,D,I,D,I,D. With MEM_ARB_DCACHE_PRIO_EN defined: D,D,D,...
- Reset mid-transaction:
  - Stimulus: proc_reset pulsed while in GRANT_D with mem_write=1; then mem_ready=1 arrives after reset.
  - Response: mem_write=0 the cycle after the reset edge; the post-reset mem_ready does not assert dc_mem_ready.
- Dropped request:
  - Stimulus: granted I deasserts ic_mem_read before ready.
  - Response: IDLE next edge; ic_mem_ready remains 0; last_grant unchanged.
